// File: rtl/tb_result_checker_if.sv
// rtl/tb_result_checker_if.sv - write bus (addr/data/wen) observed by the result checker
interface tb_result_checker_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;

  modport master (output addr, output data, output wen);
  modport slave  (input addr, input data, input wen);
endinterface

// File: rtl/tb_result_checker.sv
// rtl/tb_result_checker.sv - monitors a test port, compares result writes to an expected ROM; optional first-error capture via TB_FIRST_ERR_CAPTURE_EN
module tb_result_checker #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT = 'hFF,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 'h00000168,
  parameter int                CHECK_NUM = 7,
  parameter int                IDX_W     = 7,
  parameter logic [15:0]       TIMEOUT   = 16'hFFFF,
  parameter bit                BYTE_SWAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  tb_result_checker_if.slave   bus,
  input  logic [DATA_W-1:0]    exp_data,
  output logic [IDX_W-1:0]     exp_idx,
  output logic [7:0]           error_num,
  output logic [15:0]          duration,
  output logic                 finish,
  output logic                 timeout,
  output logic [IDX_W-1:0]     first_err_idx,
  output logic                 first_err_valid
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM);

  state_t              state_q, state_d;
  logic                wen_q;
  logic [DATA_W-1:0]   dmod;
  logic                wr_event;
  logic                check_done;
  logic [15:0]         dur_inc;
  logic [IDX_W-1:0]    exp_idx_d;
  logic [7:0]          error_num_d;
  logic [15:0]         duration_d;
  logic                timeout_d;

  // Optionally reverse byte order so the payload is compared in the sender's byte order
  always_comb begin
    dmod = bus.data;
    if (BYTE_SWAP) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        dmod[8*i +: 8] = bus.data[DATA_W-8-8*i +: 8];
      end
    end
  end

  // A burst of wen counts once: only the rising edge on the monitored port is an event
  assign wr_event   = bus.wen && !wen_q && (bus.addr == TEST_PORT);
  assign check_done = (exp_idx == LAST_IDX);
  assign dur_inc    = (duration == 16'hFFFF) ? duration : duration + 16'd1;
  assign finish     = (state_q == REPORT);

  // Next-state and counter updates; completion is tested before the timeout limit
  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx;
    error_num_d = error_num;
    duration_d  = duration;
    timeout_d   = timeout;
    case (state_q)
      IDLE: begin
        if (wr_event && (dmod == BEGIN_SYM)) begin
          state_d     = CHECK;
          exp_idx_d   = '0;
          error_num_d = 8'd0;
          duration_d  = 16'd0;
        end
      end
      CHECK: begin
        duration_d = dur_inc;
        if (check_done) begin
          state_d = REPORT;
        end else begin
          if (wr_event) begin
            exp_idx_d = exp_idx + IDX_W'(1);
            if ((dmod != exp_data) && (error_num != 8'hFF)) begin
              error_num_d = error_num + 8'd1;
            end
          end
          // duration_d is the value REPORT will show, so the limit is reached exactly
          if (dur_inc == TIMEOUT) begin
            state_d   = REPORT;
            timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and counter registers; reset aborts any test in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      exp_idx   <= '0;
      error_num <= 8'hFF;
      duration  <= 16'd0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= bus.wen;
      exp_idx   <= exp_idx_d;
      error_num <= error_num_d;
      duration  <= duration_d;
      timeout   <= timeout_d;
    end
  end

`ifdef TB_FIRST_ERR_CAPTURE_EN
  logic first_hit;
  assign first_hit = (state_q == CHECK) && !check_done && wr_event && (dmod != exp_data);

  // Latch the index of the first mismatching result; later mismatches leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (first_hit && !first_err_valid) begin
      first_err_idx   <= exp_idx;
      first_err_valid <= 1'b1;
    end
  end
`else
  assign first_err_idx   = '0;
  assign first_err_valid = 1'b0;
`endif

endmodule
